// File: rtl/mouse_tracker_if.sv
// mouse_tracker_if: groups the PS/2 byte stream, configuration write port and
// tracker outputs into one bundle.
//   master: drives rx_data/rx_valid and the cfg_* write port, observes outputs
//   slave : the tracker itself; consumes bytes/config, drives mouse_* and sync_error
interface mouse_tracker_if #(
  parameter int unsigned COORD_W = 11
);
  logic [7:0]         rx_data;
  logic               rx_valid;
  logic               cfg_we;
  logic [1:0]         cfg_sel;
  logic [COORD_W-1:0] cfg_value;
  logic [COORD_W-1:0] mouse_x;
  logic [COORD_W-1:0] mouse_y;
  logic [2:0]         mouse_buttons;
  logic               mouse_event;
  logic               sync_error;

  modport master (
    output rx_data, rx_valid, cfg_we, cfg_sel, cfg_value,
    input  mouse_x, mouse_y, mouse_buttons, mouse_event, sync_error
  );

  modport slave (
    input  rx_data, rx_valid, cfg_we, cfg_sel, cfg_value,
    output mouse_x, mouse_y, mouse_buttons, mouse_event, sync_error
  );
endinterface

// File: rtl/mouse_tracker.sv
// mouse_tracker: assembles 3-byte PS/2 mouse packets and integrates the motion
// into a clamped (x, y) cursor position with software-writable position/limits.
//   clock : rising-edge clock for all state
//   reset : asynchronous active-low reset
//   bus   : mouse_tracker_if.slave -- rx_data/rx_valid byte stream, cfg_we/cfg_sel/
//           cfg_value writes (0 X pos, 1 Y pos, 2 X max, 3 Y max), mouse_x/mouse_y/
//           mouse_buttons outputs, mouse_event and sync_error one-cycle pulses
module mouse_tracker #(
  parameter int unsigned COORD_W  = 11,
  parameter int unsigned MAX_X    = 639,
  parameter int unsigned MAX_Y    = 479,
  parameter int unsigned TIMEOUT  = 2000000,
  parameter bit          INVERT_Y = 1'b1
) (
  input logic            clock,
  input logic            reset,
  mouse_tracker_if.slave bus
);

  localparam int unsigned SW   = COORD_W + 2;
  localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {StByte0, StByte1, StByte2, StUpdate} state_e;

  // Only the header bits that matter; buttons already in {left, middle, right} order.
  typedef struct packed {
    logic       y_ovf;
    logic       x_ovf;
    logic       y_sign;
    logic       x_sign;
    logic [2:0] btn;
  } hdr_t;

  state_e             state_q, state_d;
  hdr_t               hdr_q, hdr_d;
  logic [7:0]         dx_q, dx_d, dy_q, dy_d;
  logic [CntW-1:0]    idle_q, idle_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d, max_x_q, max_x_d, max_y_q, max_y_d;
  logic [2:0]         btn_q, btn_d;
  logic               event_q, event_d, sync_q, sync_d;

  logic signed [8:0]    dx, dy;
  logic signed [SW-1:0] x_sum, y_sum, dx_ext, dy_ext, x_ext, y_ext;

  function automatic logic [COORD_W-1:0] clamp(logic signed [SW-1:0] v,
                                               logic [COORD_W-1:0] mx);
    if (v < 0) return '0;
    if (v > $signed({2'b00, mx})) return mx;
    return v[COORD_W-1:0];
  endfunction

  function automatic logic [COORD_W-1:0] umin(logic [COORD_W-1:0] a, logic [COORD_W-1:0] b);
    return (a > b) ? b : a;
  endfunction

  // Overflow saturates toward the sign of the delta.
  always_comb begin
    dx = $signed({hdr_q.x_sign, dx_q});
    dy = $signed({hdr_q.y_sign, dy_q});
    if (hdr_q.x_ovf) dx = hdr_q.x_sign ? 9'sh100 : 9'sh0FF;
    if (hdr_q.y_ovf) dy = hdr_q.y_sign ? 9'sh100 : 9'sh0FF;
    dx_ext = {{(SW-9){dx[8]}}, dx};
    dy_ext = {{(SW-9){dy[8]}}, dy};
    x_ext  = $signed({2'b00, x_q});
    y_ext  = $signed({2'b00, y_q});
    x_sum  = x_ext + dx_ext;
    y_sum  = INVERT_Y ? (y_ext - dy_ext) : (y_ext + dy_ext);
  end

  always_comb begin
    state_d = state_q;
    hdr_d   = hdr_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    x_d     = x_q;
    y_d     = y_q;
    btn_d   = btn_q;
    max_x_d = max_x_q;
    max_y_d = max_y_q;
    event_d = 1'b0;
    sync_d  = 1'b0;
    idle_d  = (bus.rx_valid || state_q == StByte0) ? '0 : idle_q + 1'b1;

    unique case (state_q)
      StByte0, StUpdate: begin
        if (state_q == StUpdate) begin
          event_d = 1'b1;
          x_d     = clamp(x_sum, max_x_q);
          y_d     = clamp(y_sum, max_y_q);
          btn_d   = hdr_q.btn;
        end
        state_d = StByte0;
        // A byte landing in UPDATE is already the next packet's header candidate.
        if (bus.rx_valid) begin
          if (bus.rx_data[3]) begin
            hdr_d   = '{y_ovf:  bus.rx_data[7], x_ovf: bus.rx_data[6],
                        y_sign: bus.rx_data[5], x_sign: bus.rx_data[4],
                        btn:    {bus.rx_data[0], bus.rx_data[2], bus.rx_data[1]}};
            state_d = StByte1;
          end else begin
            sync_d = 1'b1;
          end
        end
      end
      StByte1: begin
        if (bus.rx_valid) begin
          dx_d    = bus.rx_data;
          state_d = StByte2;
        end else if (idle_q == CntW'(TIMEOUT - 1)) begin
          state_d = StByte0;
          sync_d  = 1'b1;
        end
      end
      StByte2: begin
        if (bus.rx_valid) begin
          dy_d    = bus.rx_data;
          state_d = StUpdate;
        end else if (idle_q == CntW'(TIMEOUT - 1)) begin
          state_d = StByte0;
          sync_d  = 1'b1;
        end
      end
      default: state_d = StByte0;
    endcase

    // Config writes override the packet result for their own axis.
    if (bus.cfg_we) begin
      unique case (bus.cfg_sel)
        2'd0: x_d = umin(bus.cfg_value, max_x_q);
        2'd1: y_d = umin(bus.cfg_value, max_y_q);
        2'd2: begin
          max_x_d = bus.cfg_value;
          x_d     = umin(x_q, bus.cfg_value);
        end
        2'd3: begin
          max_y_d = bus.cfg_value;
          y_d     = umin(y_q, bus.cfg_value);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StByte0;
      hdr_q   <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      idle_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      btn_q   <= '0;
      max_x_q <= COORD_W'(MAX_X);
      max_y_q <= COORD_W'(MAX_Y);
      event_q <= 1'b0;
      sync_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      idle_q  <= idle_d;
      x_q     <= x_d;
      y_q     <= y_d;
      btn_q   <= btn_d;
      max_x_q <= max_x_d;
      max_y_q <= max_y_d;
      event_q <= event_d;
      sync_q  <= sync_d;
    end
  end

  assign bus.mouse_x       = x_q;
  assign bus.mouse_y       = y_q;
  assign bus.mouse_buttons = btn_q;
  assign bus.mouse_event   = event_q;
  assign bus.sync_error    = sync_q;

endmodule

// File: tb/tb_mouse_tracker.sv
// tb_mouse_tracker: directed, table-driven bench for mouse_tracker with TIMEOUT=100.
module tb_mouse_tracker;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clock = ~clock;

  mouse_tracker_if #(.COORD_W(11)) bus ();

  mouse_tracker #(
    .COORD_W (11),
    .MAX_X   (639),
    .MAX_Y   (479),
    .TIMEOUT (100),
    .INVERT_Y(1'b1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic        do_cfg;
    logic [1:0]  sel;
    logic [10:0] val;
    logic [7:0]  b0, b1, b2;
    logic [10:0] ex, ey;
    logic [2:0]  eb;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clock);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clock);
    bus.rx_valid = 1'b0;
  endtask

  task automatic cfg_write(input logic [1:0] sel, input logic [10:0] val);
    @(negedge clock);
    bus.cfg_we    = 1'b1;
    bus.cfg_sel   = sel;
    bus.cfg_value = val;
    @(negedge clock);
    bus.cfg_we = 1'b0;
  endtask

  // Sends a packet and checks the event lands exactly two clocks after byte 2.
  task automatic packet(input string name, input logic [7:0] b0, input logic [7:0] b1,
                        input logic [7:0] b2, input logic [10:0] ex, input logic [10:0] ey,
                        input logic [2:0] eb);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
    chk({name, ".event_early"}, 32'(bus.mouse_event), 32'd0);
    @(negedge clock);
    chk({name, ".event"}, 32'(bus.mouse_event), 32'd1);
    chk({name, ".sync"}, 32'(bus.sync_error), 32'd0);
    chk({name, ".x"}, 32'(bus.mouse_x), 32'(ex));
    chk({name, ".y"}, 32'(bus.mouse_y), 32'(ey));
    chk({name, ".btn"}, 32'(bus.mouse_buttons), 32'(eb));
    @(negedge clock);
    chk({name, ".event_once"}, 32'(bus.mouse_event), 32'd0);
  endtask

  initial begin
    bool_found: begin end
  end

  initial begin
    int hit;
    bus.rx_data   = '0;
    bus.rx_valid  = 1'b0;
    bus.cfg_we    = 1'b0;
    bus.cfg_sel   = '0;
    bus.cfg_value = '0;

    //              cfg   sel   value    b0     b1     b2     x       y       btn
    vecs[0] = '{1'b1, 2'd1, 11'd100, 8'h09, 8'h0A, 8'h05, 11'd10,  11'd95,  3'b100};
    vecs[1] = '{1'b1, 2'd0, 11'd5,   8'h18, 8'hF6, 8'h00, 11'd0,   11'd95,  3'b000};
    vecs[2] = '{1'b0, 2'd0, 11'd0,   8'h48, 8'h10, 8'h00, 11'd255, 11'd95,  3'b000};
    vecs[3] = '{1'b1, 2'd1, 11'd470, 8'h28, 8'h00, 8'hF6, 11'd255, 11'd479, 3'b000};
    vecs[4] = '{1'b0, 2'd0, 11'd0,   8'h0E, 8'h02, 8'h0A, 11'd257, 11'd469, 3'b011};
    vecs[5] = '{1'b0, 2'd0, 11'd0,   8'h88, 8'h00, 8'h33, 11'd257, 11'd214, 3'b000};
    vecs[6] = '{1'b0, 2'd0, 11'd0,   8'hA8, 8'h00, 8'h00, 11'd257, 11'd470, 3'b000};

    // Reset state
    repeat (2) @(negedge clock);
    chk("rst.x", 32'(bus.mouse_x), 32'd0);
    chk("rst.y", 32'(bus.mouse_y), 32'd0);
    chk("rst.btn", 32'(bus.mouse_buttons), 32'd0);
    chk("rst.event", 32'(bus.mouse_event), 32'd0);
    chk("rst.sync", 32'(bus.sync_error), 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 7; i++) begin
      if (vecs[i].do_cfg) cfg_write(vecs[i].sel, vecs[i].val);
      packet($sformatf("vec%0d", i), vecs[i].b0, vecs[i].b1, vecs[i].b2,
             vecs[i].ex, vecs[i].ey, vecs[i].eb);
    end

    // Max write clamps the position, and further motion stays clamped
    cfg_write(2'd0, 11'd300);
    chk("maxw.x300", 32'(bus.mouse_x), 32'd300);
    cfg_write(2'd2, 11'd100);
    chk("maxw.clamp", 32'(bus.mouse_x), 32'd100);
    packet("maxw.pkt", 8'h08, 8'h32, 8'h00, 11'd100, 11'd470, 3'b000);
    cfg_write(2'd2, 11'd639);
    chk("maxw.restore", 32'(bus.mouse_x), 32'd100);

    // Config write in the UPDATE cycle wins its axis only
    send_byte(8'h09);
    send_byte(8'h05);
    send_byte(8'h0A);
    bus.cfg_we    = 1'b1;
    bus.cfg_sel   = 2'd0;
    bus.cfg_value = 11'd20;
    @(negedge clock);
    bus.cfg_we = 1'b0;
    chk("coll.event", 32'(bus.mouse_event), 32'd1);
    chk("coll.x", 32'(bus.mouse_x), 32'd20);
    chk("coll.y", 32'(bus.mouse_y), 32'd460);
    chk("coll.btn", 32'(bus.mouse_buttons), 32'd4);

    // Resync on a header without bit 3
    send_byte(8'h00);
    chk("resync.sync", 32'(bus.sync_error), 32'd1);
    chk("resync.event", 32'(bus.mouse_event), 32'd0);
    @(negedge clock);
    chk("resync.sync_once", 32'(bus.sync_error), 32'd0);
    chk("resync.event2", 32'(bus.mouse_event), 32'd0);
    packet("resync.pkt", 8'h08, 8'h01, 8'h00, 11'd21, 11'd460, 3'b000);

    // Timeout between bytes of one packet
    send_byte(8'h08);
    send_byte(8'h05);
    hit = 0;
    for (int i = 1; i <= 120; i++) begin
      @(negedge clock);
      if (bus.mouse_event) chk("tmo.no_event", 32'(bus.mouse_event), 32'd0);
      if (bus.sync_error) begin
        hit = i;
        break;
      end
    end
    chk("tmo.cycle", 32'(hit), 32'd100);
    chk("tmo.x", 32'(bus.mouse_x), 32'd21);
    @(negedge clock);
    chk("tmo.sync_once", 32'(bus.sync_error), 32'd0);
    packet("tmo.pkt", 8'h08, 8'h03, 8'h00, 11'd24, 11'd460, 3'b000);

    // Asynchronous reset mid-packet
    send_byte(8'h08);
    send_byte(8'h05);
    #2 reset = 1'b0;
    #1;
    chk("arst.x", 32'(bus.mouse_x), 32'd0);
    chk("arst.y", 32'(bus.mouse_y), 32'd0);
    chk("arst.btn", 32'(bus.mouse_buttons), 32'd0);
    @(negedge clock);
    chk("arst.event", 32'(bus.mouse_event), 32'd0);
    chk("arst.sync", 32'(bus.sync_error), 32'd0);
    reset = 1'b1;
    packet("arst.pkt", 8'h08, 8'h02, 8'h00, 11'd2, 11'd0, 3'b000);
    // Limits came back to their reset values
    cfg_write(2'd0, 11'd700);
    chk("arst.maxx", 32'(bus.mouse_x), 32'd639);
    cfg_write(2'd1, 11'd700);
    chk("arst.maxy", 32'(bus.mouse_y), 32'd479);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mouse_tracker.md
MOUSE_TRACKER -- requirements
Module: mouse_tracker

Interface
REQ-001 The block SHALL have parameter COORD_W, default 11, giving the width of the coordinate outputs and config values.
REQ-002 The block SHALL have parameter MAX_X, default 639, giving the X bound loaded at reset.
REQ-003 The block SHALL have parameter MAX_Y, default 479, giving the Y bound loaded at reset.
REQ-004 The block SHALL have parameter TIMEOUT, default 2000000, giving the number of idle clocks allowed between bytes of one packet.
REQ-005 The block SHALL have parameter INVERT_Y, default 1; when 1, PS/2 "up" motion decreases mouse_y.
REQ-006 The block SHALL have port clock, input, 1 bit: the single 100 MHz clock; all logic is on its rising edge.
REQ-007 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-008 The block SHALL have port rx_data, input, 8 bits: a received PS/2 byte.
REQ-009 The block SHALL have port rx_valid, input, 1 bit: a one-cycle strobe qualifying rx_data.
REQ-010 The block SHALL have port cfg_we, input, 1 bit: a one-cycle configuration write strobe.
REQ-011 The block SHALL have port cfg_sel, input, 2 bits, selecting the register written: 0 = X position, 1 = Y position, 2 = X max, 3 = Y max.
REQ-012 The block SHALL have port cfg_value, input, COORD_W bits: unsigned write data.
REQ-013 The block SHALL have port mouse_x, output, COORD_W bits: registered X position.
REQ-014 The block SHALL have port mouse_y, output, COORD_W bits: registered Y position.
REQ-015 The block SHALL have port mouse_buttons, output, 3 bits: {left, middle, right}.
REQ-016 The block SHALL have port mouse_event, output, 1 bit: a one-cycle pulse when a packet has been applied.
REQ-017 The block SHALL have port sync_error, output, 1 bit: a one-cycle pulse on a discarded byte or a packet timeout.

Function
REQ-018 Packet FSM states SHALL be BYTE0, BYTE1, BYTE2 and UPDATE.
- BYTE0 -> BYTE1 on rx_valid with rx_data[3]=1; that byte is captured as the header.
- BYTE1 -> BYTE2 on rx_valid; the byte is captured as the X delta.
- BYTE2 -> UPDATE on rx_valid; the byte is captured as the Y delta.
- UPDATE -> BYTE0 unconditionally after one cycle.
REQ-019 In BYTE0, rx_valid with rx_data[3]=0 SHALL pulse sync_error, discard the byte, and stay in BYTE0.
REQ-020 An rx_valid arriving while in UPDATE SHALL be evaluated by the BYTE0 rules, so the next state is BYTE1 or BYTE0.
REQ-021 The idle counter SHALL behave as follows:
- it clears on every rx_valid and whenever the FSM is in BYTE0;
- otherwise it increments;
- if it reaches TIMEOUT-1 while in BYTE1 or BYTE2, the FSM SHALL return to BYTE0 and pulse sync_error, and the partial packet SHALL be discarded.
REQ-022 Delta formation SHALL be as follows:
- dx = signed 9-bit {hdr[4], byte1}; dy = signed 9-bit {hdr[5], byte2};
- if the X overflow bit hdr[6] is set, dx SHALL saturate to -256 when hdr[4]=1, else +255;
- the Y overflow bit hdr[7] SHALL saturate dy the same way.
REQ-023 Position arithmetic in UPDATE SHALL be as follows:
- it is done signed at COORD_W+2 bits;
- new_x = x + dx;
- new_y = y - dy when INVERT_Y=1, otherwise y + dy;
- each result is clamped to the range [0, max] of its axis.
REQ-024 The register update at the end of UPDATE SHALL be: mouse_x, mouse_y, and mouse_buttons = {hdr[0], hdr[2], hdr[1]}.
REQ-025 mouse_event SHALL be high for exactly the cycle after UPDATE, coincident with the new outputs, i.e. two clocks after the rx_valid of byte 2.
REQ-026 A configuration write SHALL take effect on the next clock edge.
REQ-027 A position write SHALL be clamped to the current max of its axis.
REQ-028 A max write SHALL also clamp the current position of that axis to the new max in the same edge.
REQ-029 When a cfg write coincides with UPDATE:
- the write SHALL win for its axis, and that axis's packet delta is discarded;
- the other axis and the buttons SHALL update normally;
- mouse_event SHALL still pulse.
REQ-030 sync_error and mouse_event SHALL never be high in the same cycle for the same packet.

Reset
REQ-031 While reset=0, the FSM SHALL be in BYTE0 and the idle counter at 0.
REQ-032 While reset=0, mouse_x=0, mouse_y=0, mouse_buttons=000, mouse_event=0 and sync_error=0.
REQ-033 While reset=0, the X and Y max registers SHALL equal MAX_X and MAX_Y.
REQ-034 Assertion of reset SHALL act immediately and asynchronously, aborting any partial packet.
REQ-035 After reset is released, the first byte SHALL be treated as BYTE0.

Verification
REQ-036 Basic packet, run with TIMEOUT=100 and all other parameters at default: cfg Y pos=100, then bytes 0x09, 0x0A, 0x05 -> mouse_x=10, mouse_y=95, mouse_buttons=100, with mouse_event pulsing 2 clocks after the third rx_valid.
REQ-037 Saturation: with x=5, send 0x18, 0xF6, 0x00 -> x=0. Then bytes 0x48, 0x10, 0x00 -> x=255 (overflow saturation).
REQ-038 Max write: with x=300, cfg X max=100 -> x=100 next clock. Then a packet with dx=+50 -> x stays 100, and mouse_event still pulses.
REQ-039 Resync: byte 0x00 in BYTE0 -> sync_error pulses and no event occurs. Then 0x08, 0x01, 0x00 -> x increments by 1.
REQ-040 Timeout: bytes 0x08, 0x05, then 100 idle clocks -> sync_error pulse and position unchanged. Then 0x08, 0x03, 0x00 -> x increases by 3.
REQ-041 Reset mid-packet: bytes 0x08, 0x05, then reset=0 for 1 cycle -> all outputs are at reset values. Then 0x08, 0x02, 0x00 -> x=2.
